// File: rtl/bnn_pkg.sv
// Shared definitions for the sequential binary neural network layers:
// controller state encoding and the width helpers used by the classifier.
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCORE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Width needed to hold a popcount in the range 0..m.
  function automatic int score_width(input int m);
    return $clog2(m + 1);
  endfunction

  // Width of a class index / class counter; never narrower than one bit.
  function automatic int idx_width(input int c);
    return (c <= 2) ? 1 : $clog2(c);
  endfunction

endpackage

// File: rtl/xnor_popcount.sv
// Combinational XNOR-popcount: number of bit positions where a and w agree.
module xnor_popcount
  import bnn_pkg::*;
#(
  parameter int M = 4,
  localparam int SW = score_width(M)
) (
  input  logic [M-1:0]  a,
  input  logic [M-1:0]  w,
  output logic [SW-1:0] count
);

  logic [M-1:0] agree;

  assign agree = ~(a ^ w);

  // Sum the agreeing positions.
  always_comb begin
    count = '0;
    for (int i = 0; i < M; i++) begin
      count = count + SW'(agree[i]);
    end
  end

endmodule

// File: rtl/seq_bin_argmax.sv
// Sequential binary argmax classifier. Latches the activation vector on a
// rising edge of start, scores one class per cycle with XNOR-popcount and
// reports the winning class index with a one-cycle valid pulse.
// Optional build macro SEQ_ARGMAX_SCORE_EN adds the max_score output.
module seq_bin_argmax
  import bnn_pkg::*;
#(
  parameter int             M       = 4,
  parameter int             C       = 3,
  parameter logic [C*M-1:0] Weights = '0,
  localparam int            SW      = score_width(M),
  localparam int            IW      = idx_width(C)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [M-1:0]  act,
  output logic          busy,
  output logic          valid,
`ifdef SEQ_ARGMAX_SCORE_EN
  output logic [SW-1:0] max_score,
`endif
  output logic [IW-1:0] class_out
);

  localparam logic [IW-1:0] LAST = IW'(C - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] best_q, best_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [M-1:0]  act_q, act_d;
  logic          start_q;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] class_q, class_d;
`ifdef SEQ_ARGMAX_SCORE_EN
  logic [SW-1:0] max_score_q, max_score_d;
`endif

  logic          accept;
  logic          better;
  logic [M-1:0]  w_sel;
  logic [SW-1:0] score;
  logic [M-1:0]  w_tab [C];

  // Unpack the flat weight vector into one row per class.
  for (genvar gi = 0; gi < C; gi++) begin : g_wtab
    assign w_tab[gi] = Weights[gi*M +: M];
  end

  assign w_sel = w_tab[cnt_q];

  xnor_popcount #(.M(M)) u_popcount (
    .a     (act_q),
    .w     (w_sel),
    .count (score)
  );

  // Only a fresh rising edge seen while idle starts a run, so a level-held
  // done from upstream cannot retrigger.
  assign accept = start & ~start_q & (state_q == IDLE);
  // The first class always seeds the running best; later ones must beat it
  // strictly so ties keep the lower index.
  assign better = (cnt_q == '0) || (score > best_q);

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    best_d  = best_q;
    idx_d   = idx_q;
    act_d   = act_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    class_d = class_q;
`ifdef SEQ_ARGMAX_SCORE_EN
    max_score_d = max_score_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          act_d   = act;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SCORE;
        end
      end
      SCORE: begin
        if (better) begin
          best_d = score;
          idx_d  = cnt_q;
        end
        if (cnt_q == LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          // Fold in the last class's compare directly.
          class_d = better ? cnt_q : idx_q;
`ifdef SEQ_ARGMAX_SCORE_EN
          max_score_d = better ? score : best_q;
`endif
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      best_q  <= '0;
      idx_q   <= '0;
      act_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      class_q <= '0;
`ifdef SEQ_ARGMAX_SCORE_EN
      max_score_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      best_q  <= best_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      start_q <= start;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      class_q <= class_d;
`ifdef SEQ_ARGMAX_SCORE_EN
      max_score_q <= max_score_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign class_out = class_q;
`ifdef SEQ_ARGMAX_SCORE_EN
  assign max_score = max_score_q;
`endif

endmodule

// File: tb/tb_seq_bin_argmax.sv
// Self-checking bench for seq_bin_argmax (M=4, C=3). Honours the optional
// SEQ_ARGMAX_SCORE_EN build macro for the max_score output.
module tb_seq_bin_argmax;

  localparam int          M = 4;
  localparam int          C = 3;
  localparam logic [11:0] W = 12'b1111_0011_0000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] act = '0;
  logic       busy;
  logic       valid;
  logic [1:0] class_out;
`ifdef SEQ_ARGMAX_SCORE_EN
  logic [2:0] max_score;
`endif

  int n_cmp = 0;
  int n_err = 0;

  seq_bin_argmax #(.M(M), .C(C), .Weights(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .act       (act),
    .busy      (busy),
    .valid     (valid),
`ifdef SEQ_ARGMAX_SCORE_EN
    .max_score (max_score),
`endif
    .class_out (class_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] act;
    int         cls;
    int         sc;
  } vec_t;

  vec_t tbl[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: score every class directly, keep the first maximum.
  function automatic void model(input logic [3:0] a, output int cls, output int sc);
    logic [11:0] wv;
    logic [3:0]  agree;
    int          s;
    wv  = W;
    cls = 0;
    sc  = -1;
    for (int k = 0; k < C; k++) begin
      agree = ~(a ^ wv[k*4 +: 4]);
      s = $countones(agree);
      if (s > sc) begin
        sc  = s;
        cls = k;
      end
    end
  endfunction

  task automatic check_score(input string name, input int exp);
`ifdef SEQ_ARGMAX_SCORE_EN
    check(name, int'(max_score), exp);
`endif
  endtask

  // One full run: pulse start, scramble act afterwards, check timing and result.
  task automatic run_one(input logic [3:0] a, input int exp_cls, input int exp_sc,
                         input string tag);
    int cycles;
    int busy_cnt;
    start = 1'b0;
    tick();
    act   = a;
    start = 1'b1;
    tick();
    check({tag, "_busy_after_accept"}, int'(busy), 1);
    start    = 1'b0;
    act      = 4'($urandom);
    cycles   = 0;
    busy_cnt = 1;
    while (!valid && cycles < 20) begin
      tick();
      cycles++;
      if (busy) busy_cnt++;
    end
    check({tag, "_latency"}, cycles, C);
    check({tag, "_class"}, int'(class_out), exp_cls);
    check({tag, "_busy_cycles"}, busy_cnt, C);
    check_score({tag, "_max_score"}, exp_sc);
    $display("run %s act=%b class_out=%0d expected=%0d latency=%0d", tag, a, class_out,
             exp_cls, cycles);
    tick();
    check({tag, "_valid_pulse"}, int'(valid), 0);
    check({tag, "_class_held"}, int'(class_out), exp_cls);
  endtask

  initial begin
    int cls;
    int sc;
    int pulses;

    tbl[0] = '{4'b1111, 2, 4};
    tbl[1] = '{4'b0000, 0, 4};
    tbl[2] = '{4'b0011, 1, 4};
    tbl[3] = '{4'b0001, 0, 3};

    // Reset state
    rst = 1'b0;
    tick();
    tick();
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_class", int'(class_out), 0);
    check_score("reset_max_score", 0);
    rst = 1'b1;
    tick();

    // Directed table, expected values written from the hand-computed scores
    for (int i = 0; i < 4; i++) begin
      run_one(tbl[i].act, tbl[i].cls, tbl[i].sc, $sformatf("tbl%0d", i));
    end

    // Level-held start: exactly one run
    start = 1'b0;
    tick();
    act    = 4'b1111;
    start  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (valid) pulses++;
    end
    check("level_pulses", pulses, 1);
    check("level_class", int'(class_out), 2);
    check("level_busy_idle", int'(busy), 0);
    $display("run level_hold act=1111 pulses=%0d class_out=%0d", pulses, class_out);
    start = 1'b0;
    tick();
    tick();
    check("level_no_rerun", int'(busy), 0);

    // Mid-run reset on the second SCORE cycle
    act   = 4'b1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_class", int'(class_out), 0);
    $display("run mid_reset busy=%0d valid=%0d class_out=%0d", busy, valid, class_out);
    rst = 1'b1;
    tick();
    run_one(4'b0011, 1, 4, "after_rst");

    // Second start edge during SCORE with a different act is ignored
    start = 1'b0;
    tick();
    act   = 4'b0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    act   = 4'b1111;
    tick();
    start  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid) pulses++;
      if (i == 2) start = 1'b0;
    end
    check("reedge_pulses", pulses, 1);
    check("reedge_class", int'(class_out), 0);
    $display("run reedge act=0000 pulses=%0d class_out=%0d", pulses, class_out);

    // Random activations against the reference model
    for (int i = 0; i < 30; i++) begin
      logic [3:0] a;
      a = 4'($urandom);
      model(a, cls, sc);
      run_one(a, cls, sc, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
